// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and
// the opcode classification helper.
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_MOD  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_NAND = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1001;
    localparam logic [3:0] OP_XNOR = 4'b1010;
    localparam logic [3:0] OP_XOR  = 4'b1011;
    localparam logic [3:0] OP_SHL  = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_EQ   = 4'b1110;
    localparam logic [3:0] OP_NE   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // MUL and DIV are the multi-cycle paths through the ALU.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq.sv
// Operand/command sequencer in front of the combinational ALU: registers the
// operands, waits the op's settling time, captures D/Cout with status flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int MULDIV_CYCLES = 4,
    parameter int BASIC_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [3:0]       S,
    output logic             Cin,
    input  logic [WIDTH-1:0] D,
    input  logic             Cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_cout,
    output logic             res_zero,
    output logic             res_neg,
    output logic             res_err
);

    localparam int MAXC = (MULDIV_CYCLES > BASIC_CYCLES) ? MULDIV_CYCLES : BASIC_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MD_LOAD    = CW'(MULDIV_CYCLES - 1);
    localparam logic [CW-1:0] BASIC_LOAD = CW'(BASIC_CYCLES - 1);

    seq_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_nop;
    logic             r_dz;
    logic             r_cmd_ready;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_s;
    logic             r_cin;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_cout;
    logic             r_res_zero;
    logic             r_res_neg;
    logic             r_res_err;

    logic             w_accept;
    logic             w_dz_cmd;
    logic [CW-1:0]    w_load;
    logic [WIDTH-1:0] w_cap_data;
    logic             w_cap_cout;

    // Accept decode, counter preload and the value to capture at end of EXEC.
    always_comb begin
        w_accept   = cmd_valid & r_cmd_ready;
        w_dz_cmd   = (cmd_op == OP_DIV) && (cmd_b == {WIDTH{1'b0}});
        w_load     = BASIC_LOAD;
        w_cap_data = D;
        w_cap_cout = 1'b0;
        if (w_dz_cmd) begin
            w_load = {CW{1'b0}};
        end else if (is_muldiv(cmd_op)) begin
            w_load = MD_LOAD;
        end else begin
            w_load = BASIC_LOAD;
        end
        if (r_nop) begin
            w_cap_data = {WIDTH{1'b0}};
        end else if (r_dz) begin
            w_cap_data = {WIDTH{1'b1}};
        end else begin
            w_cap_data = D;
            w_cap_cout = ((r_s == OP_ADD) || (r_s == OP_SUB)) ? Cout : 1'b0;
        end
    end

    // Sequencer FSM, latency counter, ALU input registers and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CW{1'b0}};
            r_nop       <= 1'b0;
            r_dz        <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_s         <= 4'b0000;
            r_cin       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= {WIDTH{1'b0}};
            r_res_cout  <= 1'b0;
            r_res_zero  <= 1'b0;
            r_res_neg   <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a         <= cmd_a;
                        r_b         <= cmd_b;
                        r_s         <= cmd_op;
                        r_cin       <= cmd_cin;
                        r_nop       <= (cmd_op == OP_NOP);
                        r_dz        <= w_dz_cmd;
                        r_cnt       <= w_load;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_EXEC;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == {CW{1'b0}}) begin
                        r_res_data  <= w_cap_data;
                        r_res_cout  <= w_cap_cout;
                        r_res_zero  <= (w_cap_data == {WIDTH{1'b0}});
                        r_res_neg   <= w_cap_data[WIDTH-1];
                        r_res_err   <= r_dz;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_res_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b0;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign A         = r_a;
    assign B         = r_b;
    assign S         = r_s;
    assign Cin       = r_cin;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_cout  = r_res_cout;
    assign res_zero  = r_res_zero;
    assign res_neg   = r_res_neg;
    assign res_err   = r_res_err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with a behavioural ALU attached.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        cmd_cin;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  S;
    logic        Cin;
    logic [31:0] D;
    logic        Cout;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_cout;
    logic        res_zero;
    logic        res_neg;
    logic        res_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .MULDIV_CYCLES(4), .BASIC_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
        .A(A), .B(B), .S(S), .Cin(Cin), .D(D), .Cout(Cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cout(res_cout), .res_zero(res_zero), .res_neg(res_neg), .res_err(res_err)
    );

    // Behavioural ALU for the opcodes exercised here.
    always_comb begin
        D    = 32'd0;
        Cout = 1'b0;
        case (S)
            4'b0001: {Cout, D} = {1'b0, A} + {1'b0, B} + {32'd0, Cin};
            4'b0010: {Cout, D} = {1'b0, A} - {1'b0, B} - {32'd0, Cin};
            4'b0011: D = A * B;
            4'b0100: D = (B != 32'd0) ? A / B : 32'd0;
            4'b1011: D = A ^ B;
            default: D = 32'd0;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Waits for cmd_ready, presents one command, returns after the accept edge.
    task automatic send_cmd(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic cin);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_val({tag, "_ready_timeout"}, 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_cin   = cin;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Counts edges from accept to res_valid and checks cmd_ready stayed low.
    task automatic wait_result(input string tag, input int exp_lat);
        int  lat;
        bit  rdy_seen;
        lat      = 0;
        rdy_seen = 1'b0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (cmd_ready) rdy_seen = 1'b1;
            if (res_valid) break;
        end
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_rdy_low"}, {31'd0, rdy_seen}, 32'd0);
    endtask

    task automatic check_res(input string tag, input logic [31:0] data, input logic cout,
                             input logic zero, input logic neg, input logic err);
        check_val({tag, "_data"}, res_data, data);
        check_val({tag, "_flags"}, {28'd0, res_cout, res_zero, res_neg, res_err},
                  {28'd0, cout, zero, neg, err});
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check_val({tag, "_vfall"}, {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 32'd0; cmd_b = 32'd0;
        cmd_cin = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check_val("rst_valid", {31'd0, res_valid}, 32'd0);
        check_val("rst_A", A, 32'd0);
        check_val("rst_S", {28'd0, S}, 32'd0);
        rst = 1'b0;

        send_cmd("add", 4'b0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_result("add", 1);
        check_res("add", 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
        consume("add");

        send_cmd("mul", 4'b0011, 32'd7, 32'd6, 1'b0);
        wait_result("mul", 4);
        check_res("mul", 32'd42, 1'b0, 1'b0, 1'b0, 1'b0);
        consume("mul");

        send_cmd("dz", 4'b0100, 32'd10, 32'd0, 1'b0);
        wait_result("dz", 1);
        check_res("dz", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        consume("dz");

        send_cmd("div", 4'b0100, 32'd10, 32'd3, 1'b0);
        wait_result("div", 4);
        check_res("div", 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        consume("div");

        // Backpressure: result held while a new command waits on cmd_valid.
        send_cmd("xor", 4'b1011, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0);
        wait_result("xor", 1);
        check_res("xor", 32'h0F0F_F0F0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmd_valid = 1'b1; cmd_op = 4'b0001; cmd_a = 32'd1; cmd_b = 32'd2; cmd_cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_hold", {res_valid, cmd_ready, 26'd0, S}, {1'b1, 1'b0, 26'd0, 4'b1011});
            check_val("bp_data", res_data, 32'h0F0F_F0F0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check_val("bp_release", {29'd0, res_valid, cmd_ready, 1'b0}, {29'd0, 1'b0, 1'b1, 1'b0});
        check_val("bp_not_yet", {28'd0, S}, {28'd0, 4'b1011});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check_val("bp_accept", {28'd0, S}, {28'd0, 4'b0001});
        wait_result("bp_add", 1);
        check_res("bp_add", 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        consume("bp_add");

        send_cmd("nop", 4'b0000, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        wait_result("nop", 1);
        check_res("nop", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        consume("nop");

        send_cmd("sub", 4'b0010, 32'd3, 32'd5, 1'b0);
        wait_result("sub", 1);
        check_res("sub", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0);
        consume("sub");

        // Reset during the EXEC of a MUL discards it.
        send_cmd("rmul", 4'b0011, 32'd9, 32'd9, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        check_val("mid_rst_ab", A | B, 32'd0);
        check_val("mid_rst_sc", {27'd0, S, Cin}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("mid_rst_stale", {31'd0, res_valid}, 32'd0);
        end
        check_val("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Operand/command sequencer placed directly upstream of the 32-bit combinational ALU (ports A, B, S, Cin -> D, Cout); it also captures the ALU result.
- Accepts one ALU command per transaction over a valid/ready handshake and registers the operands onto the ALU inputs.
- Waits an op-dependent settling time (multi-cycle path for MUL/DIV), then captures D/Cout with status flags and presents them on a valid/ready result interface.
- Also filters divide-by-zero and NOP, which the ALU does not define.

Parameters:
- WIDTH, 32, datapath width; must match the ALU.
- MULDIV_CYCLES, 4, settling cycles allowed for S=0011 (MUL) and S=0100 (DIV); must be >=1.
- BASIC_CYCLES, 1, settling cycles for all other ops; must be >=1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  4  ALU opcode (same encoding as ALU S)
- cmd_a  input  WIDTH  operand A
- cmd_b  input  WIDTH  operand B
- cmd_cin  input  1  carry-in
- A  output  WIDTH  registered operand A to ALU
- B  output  WIDTH  registered operand B to ALU
- S  output  4  registered opcode to ALU
- Cin  output  1  registered carry-in to ALU
- D  input  WIDTH  ALU result
- Cout  input  1  ALU carry-out
- res_valid  output  1  result available
- res_ready  input  1  consumer takes result
- res_data  output  WIDTH  captured result
- res_cout  output  1  captured carry (ADD/SUB only, else 0)
- res_zero  output  1  res_data == 0
- res_neg  output  1  res_data[WIDTH-1]
- res_err  output  1  divide-by-zero flag

Behaviour:
- Reset:
  - All outputs, state and counter clear to 0; state = IDLE.
  - cmd_ready = 0 while rst = 1.
  - A reset mid-transaction discards the command and any held result; no res_valid follows.
- States: IDLE, EXEC, DONE. There is no overlap; one command is in flight at a time.
- IDLE:
  - cmd_ready = 1, res_valid = 0.
  - On an edge with cmd_valid & cmd_ready, latch cmd_a/b/op/cin into A/B/S/Cin.
  - Load the counter with (MULDIV_CYCLES-1) for 0011/0100, else (BASIC_CYCLES-1); go to EXEC.
- EXEC:
  - cmd_ready = 0; A/B/S/Cin held stable.
  - Counter decrements each edge.
  - On the edge where counter == 0:
    - Capture res_data <= D.
    - Capture res_cout <= Cout if S in {0001, 0010}, else 0.
    - Compute res_zero/res_neg from the captured value; go to DONE.
- Latency: command accepted at edge k -> res_valid high after edge k+N, where N is the op's cycle count (BASIC: k+1, MULDIV default: k+4).
- Special cases, decided at accept:
  - S = 0000 (NOP): skips ALU capture; res_data = 0, res_cout = 0, res_zero = 1, same latency as a BASIC op.
  - S = 0100 with cmd_b == 0: res_err = 1, res_data = all-ones, res_cout = 0, res_neg = 1, latency 1 (no MULDIV wait).
  - res_err = 0 for every other case.
- DONE:
  - res_valid = 1; all res_* held stable while res_ready = 0.
  - On an edge with res_ready = 1, go to IDLE; res_valid falls.
  - The next command is accepted no earlier than the following edge (cmd_ready rises after the DONE->IDLE edge).
- cmd_valid during EXEC/DONE is ignored; the producer must hold its command until cmd_ready.
- A/B/S/Cin keep their last values in IDLE; there is no glitching of ALU inputs outside an accept edge.
- No arithmetic in this block beyond the zero compare and the divide-by-zero compare; widths all WIDTH, no truncation.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams OP_NOP=0000, OP_ADD=0001, OP_SUB=0010, OP_MUL=0011, OP_DIV=0100 … OP_NE=1111.
  - State encoding IDLE/EXEC/DONE.
  - Helper function is_muldiv(op).
- Sub-module: none required; the latency down-counter stays inline. The ALU itself is instantiated by the parent alongside this block, not inside it.

Test Plan:
- ADD: op=0001, a=FFFFFFFF, b=00000001, cin=0, res_ready=1 -> res_valid one cycle after accept; res_data=0, res_cout=1, res_zero=1, res_err=0.
- MUL latency: op=0011, a=7, b=6, MULDIV_CYCLES=4 -> res_valid exactly 4 edges after accept, res_data=42; cmd_ready low throughout.
- DIV by zero: op=0100, a=10, b=0 -> res_valid after 1 edge, res_err=1, res_data=FFFFFFFF, res_neg=1; next op=0100, a=10, b=3 -> res_data=3, res_err=0.
- Backpressure: op=1011, a=F0F0F0F0, b=FFFF0000, res_ready=0 for 5 cycles -> res_valid and res_data=0F0FF0F0 stay stable, cmd_ready stays 0, and a new cmd_valid is ignored until after res_ready=1.
- NOP and SUB flags: op=0000 -> res_data=0, res_zero=1; then op=0010, a=3, b=5, cin=0 -> res_data=FFFFFFFE, res_neg=1.
- Reset mid-op: assert rst during the EXEC of a MUL -> next edge: state IDLE, res_valid=0, A/B/S/Cin=0; no stale result after rst deasserts.
